// File: rtl/memory_dumper_if.sv
// Command/RAM/stream bundle for memory_dumper.
//   master: the dumper (drives mem_read/mem_addr and the out_* stream, busy, done)
//   slave : the environment (drives start/base_addr/word_count, mem_read_data, out_ready)
interface memory_dumper_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] word_count;
    logic                  mem_read;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, base_addr, word_count, mem_read_data, out_ready,
        output mem_read, mem_addr, out_data, out_addr, out_valid, out_last, busy, done
    );

    modport slave (
        output start, base_addr, word_count, mem_read_data, out_ready,
        input  mem_read, mem_addr, out_data, out_addr, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/memory_dumper.sv
// Reads word_count consecutive RAM words starting at base_addr and streams
// each one out with its address over a valid/ready handshake, 3 cycles/word.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : memory_dumper_if.master (start command, RAM read port, output stream, status)
// All outputs are registered; each flop is loaded from the next-state value
// so outputs line up with the state they belong to.
module memory_dumper #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    memory_dumper_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic                  mem_read_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  busy_q;
    logic                  done_q;

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d      = bus.base_addr;
                    remaining_d = bus.word_count;
                    state_d     = (bus.word_count == ADDR_WIDTH'(0)) ? DONE : READ;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                out_data_d = bus.mem_read_data;
                out_addr_d = addr_q;
                state_d    = SEND;
            end
            SEND: begin
                // out_valid is always high in SEND, so out_ready alone completes the handshake
                if (bus.out_ready) begin
                    if (remaining_q > ADDR_WIDTH'(1)) begin
                        remaining_d = remaining_q - ADDR_WIDTH'(1);
                        addr_d      = addr_q + ADDR_WIDTH'(1);
                        state_d     = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            mem_read_q  <= (state_d == READ);
            out_valid_q <= (state_d == SEND);
            out_last_q  <= (state_d == SEND) && (remaining_d == ADDR_WIDTH'(1));
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_addr  = addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
